// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, default reset PC and the
// instruction-fetch state encoding.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry skid register that parks a fetched word while decode is stalled.
module if_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] hold_pc,
    output logic [31:0] hold_instr,
    output logic        hold_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
        end
    end

    // Payload needs no reset; it is only ever observed behind hold_valid.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            hold_pc    <= pc_in;
            hold_instr <= instr_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake
// and fills the IF/ID register, tolerating decode stalls and redirects.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_instr;
    logic         hold_valid;
    logic         accept;
    logic         pc_adv;
    logic         ifid_load;
    logic         ifid_bubble;
    logic         ifid_release;
    logic         hold_load;
    logic         hold_clear;
    logic         drain_arm;

    // Request side depends only on registered state, never on stall/redirect.
    always_comb begin
        imem_req  = (state != HOLD);
        imem_addr = (state == DRAIN) ? req_addr : pc;
    end

    assign accept = imem_req & imem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_adv       = 1'b0;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_release = 1'b0;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        drain_arm    = 1'b0;
        if (redirect) begin
            ifid_bubble = 1'b1;
            hold_clear  = 1'b1;
            case (state)
                FETCH: begin
                    // An unanswered request cannot be withdrawn; remember it and drain.
                    if (!accept) begin
                        drain_arm = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
                HOLD:    state_nxt = FETCH;
                DRAIN:   if (accept) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_adv = 1'b1;
                        if (stall) begin
                            hold_load = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_release = 1'b1;
                        hold_clear   = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                DRAIN:   if (accept) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (pc_adv) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (drain_arm) begin
            req_addr <= pc;
        end
    end

    // IF/ID pipeline register; a bubble leaves if_pc as-is since ID ignores it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pc          <= RESET_PC;
            if_instruction <= NOP;
            if_valid       <= 1'b0;
        end else if (ifid_bubble) begin
            if_instruction <= NOP;
            if_valid       <= 1'b0;
        end else if (ifid_load) begin
            if_pc          <= pc;
            if_instruction <= imem_rdata;
            if_valid       <= 1'b1;
        end else if (ifid_release) begin
            if_pc          <= hold_pc;
            if_instruction <= hold_valid ? hold_instr : NOP;
            if_valid       <= hold_valid;
        end
    end

    if_hold_buf u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .clear      (hold_clear),
        .pc_in      (pc),
        .instr_in   (imem_rdata),
        .hold_pc    (hold_pc),
        .hold_instr (hold_instr),
        .hold_valid (hold_valid)
    );

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline; the producer side of the IF/ID interface that the decode stage consumes. Owns the program counter and drives a stall-tolerant, variable-latency request/ready handshake to instruction memory. Registers each fetched word with its PC into the IF/ID pipeline register. Handles decode-stage stalls and branch/flush redirects, including discarding a response that is still in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be zero.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  ID cannot accept; the IF/ID register holds.
- redirect  in  1  branch taken or flush; discard all younger work.
- redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response valid this cycle; may be high in the same cycle imem_req rises.
- imem_rdata  in  32  instruction word; sampled only when imem_req & imem_ready.
- if_pc  out  32  PC of the instruction in IF/ID; ID forms PC+4 from this value.
- if_instruction  out  32  instruction in IF/ID; 32'h0000_0000 (NOP) when invalid.
- if_valid  out  1  IF/ID holds a real instruction.

## Operation
- State machine with three states: FETCH, HOLD, DRAIN. Reset state is FETCH.
- Registers: pc, req_addr, hold_pc, hold_instr, and the IF/ID register.
- A transfer ("accept") occurs when imem_req & imem_ready.
- **FETCH:** imem_req=1, imem_addr=pc.
  - accept & !stall: IF/ID←{pc, rdata, valid=1}; pc←pc+4.
  - accept & stall: hold←{pc, rdata}; pc←pc+4; go to HOLD.
  - no accept & !stall: IF/ID←bubble (pc value is don't-care, instr 0, valid 0).
  - no accept & stall: IF/ID holds.
- **HOLD:** imem_req=0. When stall=0: IF/ID←{hold_pc, hold_instr, valid=1}; go to FETCH.
- **DRAIN:** imem_req=1, imem_addr=req_addr (the abandoned address). On accept, discard rdata and go to FETCH. imem_addr and pc are then the redirect target.
- **Redirect:** has priority over stall and over every other event.
  - IF/ID←bubble; hold contents are discarded; pc←{redirect_pc[31:2], 2'b00}.
  - In FETCH, if no accept this cycle: req_addr←old pc; go to DRAIN.
  - In FETCH, if accept this cycle: rdata is dropped; stay in FETCH.
  - In HOLD: go to FETCH.
  - In DRAIN: pc is updated to the new target; stay in DRAIN until accept.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).

## Timing
- Reset values: if_pc=RESET_PC, if_instruction=0, if_valid=0, imem_req=1 (first cycle after reset deassertion), imem_addr=RESET_PC, state=FETCH.
- Latency: the word accepted at edge N is visible on IF/ID after edge N (or after stall falls, if held in HOLD).
- Throughput: with imem_ready=1 and stall=0, one instruction per cycle; PCs advance by 4 every cycle.
- Redirect asserted in cycle N: if_valid=0 after edge N. The first target instruction appears one edge after its accept.
- Reset mid-transfer: the outstanding request is abandoned and imem_req restarts at RESET_PC. The memory model must tolerate a request being withdrawn.
- imem_req and imem_addr are pure functions of state and registers; they have no combinational path from stall or redirect.

## Structure
- Shared package mips_pkg holds:
  - NOP constant 32'h0000_0000;
  - default reset PC;
  - the fetch state encoding (FETCH, HOLD, DRAIN).
- One natural sub-module, if_hold_buf: the single-entry skid register (hold_pc, hold_instr, load/clear). The FSM, PC and IF/ID register stay in if_stage.

## Test plan
- **Reset and stream:** RESET_PC=0x100, imem_ready=1, stall=0. Required: IF/ID shows 0x100, 0x104, 0x108 on consecutive cycles, all with if_valid=1.
- **Stall capture:** stall high for 3 cycles while a word at 0x104 is accepted. Required: imem_req drops, IF/ID keeps 0x100, then 0x104 appears the edge after stall falls, then fetch resumes at 0x108.
- **Redirect during wait:** ready low at 0x108, redirect to 0x2002. Required: IF/ID becomes a bubble, imem_addr stays 0x108 until ready, that word is discarded, then the next request is 0x2000.
- **Redirect during stall:** redirect while in HOLD. Required: held word dropped, if_valid=0, next request at the target.
- **Wrap:** redirect to 0xFFFFFFFC. Required: following request is 0x00000000.
- **Async reset:** reset pulsed mid-stream between clock edges. Required: outputs reach their reset values immediately, and fetch restarts at RESET_PC.
